// File: rtl/mux_add_pkg.sv
// Shared definitions for the mux/add/accumulate arithmetic stage.
package mux_add_pkg;

   typedef enum logic [1:0] {
      MODE_ADD = 2'b00,
      MODE_ACC = 2'b01,
      MODE_SUB = 2'b10,
      MODE_CLR = 2'b11
   } mode_t;

   // A one-channel mux still needs a 1-bit select port.
   function automatic int sel_width(input int nch);
      return (nch > 1) ? $clog2(nch) : 1;
   endfunction

endpackage

// File: rtl/mux_add_acc_op_mux.sv
// NCH:1 combinational operand selector; out-of-range selects yield zero and raise sel_err.
module op_mux
   import mux_add_pkg::*;
#(
   parameter int  WIDTH = 4,
   parameter int  NCH   = 2,
   localparam int SEL_W = sel_width(NCH)
) (
   input  logic [NCH*WIDTH-1:0] ops,
   input  logic [SEL_W-1:0]     sel,
   output logic [WIDTH-1:0]     op,
   output logic                 sel_err
);

   always_comb begin
      op      = '0;
      sel_err = 1'b1;
      for (int k = 0; k < NCH; k++) begin
         if (sel == SEL_W'(k)) begin
            op      = ops[k*WIDTH +: WIDTH];
            sel_err = 1'b0;
         end
      end
   end

endmodule

// File: rtl/mux_add_acc.sv
// Operand select + add/accumulate/subtract stage with a single registered output
// slot and valid/ready handshakes on both sides.
module mux_add_acc
   import mux_add_pkg::*;
#(
   parameter int  WIDTH = 4,
   parameter int  NCH   = 2,
   localparam int SEL_W = sel_width(NCH)
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [WIDTH-1:0]     a,
   input  logic [NCH*WIDTH-1:0] ops,
   input  logic [SEL_W-1:0]     sel,
   input  logic [1:0]           mode,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [WIDTH-1:0]     res,
   output logic                 carry,
   output logic                 ovf,
   output logic                 sel_err
);

   function automatic logic add_ovf(input logic l_msb, input logic o_msb, input logic s_msb);
      return (l_msb == o_msb) && (s_msb != l_msb);
   endfunction

   function automatic logic sub_ovf(input logic l_msb, input logic o_msb, input logic s_msb);
      return (l_msb != o_msb) && (s_msb != l_msb);
   endfunction

   logic [WIDTH-1:0] op;
   logic             sel_err_c;
   mode_t            mode_c;
   logic             accept;

   logic signed [WIDTH-1:0] lhs;
   logic        [WIDTH:0]   sum;
   logic                    ovf_c;

   logic [WIDTH-1:0] acc_p1;
   logic [WIDTH-1:0] res_p1;
   logic             carry_p1;
   logic             ovf_p1;
   logic             serr_p1;
   logic             vld_p1;

   op_mux #(
      .WIDTH (WIDTH),
      .NCH   (NCH)
   ) u_op_mux (
      .ops     (ops),
      .sel     (sel),
      .op      (op),
      .sel_err (sel_err_c)
   );

   assign mode_c   = mode_t'(mode);
   assign in_ready = !vld_p1 || out_ready;
   assign accept   = in_valid && in_ready;

   // Stage p0: operand select and WIDTH+1 bit arithmetic; bit WIDTH is carry or borrow.
   always_comb begin
      lhs   = (mode_c == MODE_ADD) ? a : acc_p1;
      sum   = '0;
      ovf_c = 1'b0;
      if (mode_c == MODE_SUB) begin
         sum   = {1'b0, lhs} - {1'b0, op};
         ovf_c = sub_ovf(lhs[WIDTH-1], op[WIDTH-1], sum[WIDTH-1]);
      end else begin
         sum   = {1'b0, lhs} + {1'b0, op};
         ovf_c = add_ovf(lhs[WIDTH-1], op[WIDTH-1], sum[WIDTH-1]);
      end
   end

   // Stage p1: output slot; a drain and a new accept in the same cycle simply overwrite.
   always_ff @(posedge clk) begin
      if (rst) begin
         vld_p1   <= 1'b0;
         acc_p1   <= '0;
         res_p1   <= '0;
         carry_p1 <= 1'b0;
         ovf_p1   <= 1'b0;
         serr_p1  <= 1'b0;
      end else if (accept) begin
         vld_p1  <= 1'b1;
         serr_p1 <= sel_err_c;
         if (mode_c == MODE_CLR) begin
            acc_p1   <= '0;
            res_p1   <= '0;
            carry_p1 <= 1'b0;
            ovf_p1   <= 1'b0;
         end else begin
            res_p1   <= sum[WIDTH-1:0];
            carry_p1 <= sum[WIDTH];
            ovf_p1   <= ovf_c;
            if (mode_c != MODE_ADD) begin
               acc_p1 <= sum[WIDTH-1:0];
            end
         end
      end else if (out_ready) begin
         vld_p1 <= 1'b0;
      end
   end

   assign out_valid = vld_p1;
   assign res       = res_p1;
   assign carry     = carry_p1;
   assign ovf       = ovf_p1;
   assign sel_err   = serr_p1;

endmodule

// File: tb/tb_mux_add_acc.sv
// Bench for mux_add_acc: table of vectors plus random ADD beats scored through
// an expected-result queue, and directed backpressure / reset / NCH=3 sequences.
module tb_mux_add_acc;
   import mux_add_pkg::*;

   typedef struct packed {
      logic [3:0] res;
      logic       carry;
      logic       ovf;
      logic       serr;
   } exp_t;

   typedef struct {
      logic [1:0] mode;
      logic [3:0] a;
      logic [3:0] ch0;
      logic [3:0] ch1;
      logic       s;
      exp_t       e;
   } vec_t;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   logic       in_valid, in_ready, out_valid, out_ready;
   logic [3:0] a, res;
   logic [7:0] ops;
   logic [0:0] sel;
   logic [1:0] mode;
   logic       carry, ovf, sel_err;

   logic       in_valid3, in_ready3, out_valid3, out_ready3;
   logic [3:0] a3, res3;
   logic [11:0] ops3;
   logic [1:0] sel3;
   logic [1:0] mode3;
   logic       carry3, ovf3, sel_err3;

   mux_add_acc #(.WIDTH(4), .NCH(2)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .a(a), .ops(ops), .sel(sel), .mode(mode),
      .out_valid(out_valid), .out_ready(out_ready),
      .res(res), .carry(carry), .ovf(ovf), .sel_err(sel_err)
   );

   mux_add_acc #(.WIDTH(4), .NCH(3)) dut3 (
      .clk(clk), .rst(rst), .in_valid(in_valid3), .in_ready(in_ready3),
      .a(a3), .ops(ops3), .sel(sel3), .mode(mode3),
      .out_valid(out_valid3), .out_ready(out_ready3),
      .res(res3), .carry(carry3), .ovf(ovf3), .sel_err(sel_err3)
   );

   exp_t q[$];
   exp_t mon_e;
   vec_t tbl[$];
   int   checks = 0;
   int   errors = 0;
   logic rand_bp = 1'b0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h", name, act, req);
      end
   endtask

   function automatic exp_t mk_e(input logic [3:0] r, input logic c, input logic o);
      exp_t e;
      e.res   = r;
      e.carry = c;
      e.ovf   = o;
      e.serr  = 1'b0;
      return e;
   endfunction

   function automatic vec_t mk(input logic [1:0] m, input logic [3:0] aa, input logic [3:0] c0,
                               input logic [3:0] c1, input logic s, input logic [3:0] r,
                               input logic c, input logic o);
      vec_t v;
      v.mode = m;
      v.a    = aa;
      v.ch0  = c0;
      v.ch1  = c1;
      v.s    = s;
      v.e    = mk_e(r, c, o);
      return v;
   endfunction

   // Integer reference for ADD: unsigned carry and signed-range overflow.
   function automatic exp_t ref_add(input int l, input int o);
      int s, sl, so;
      s  = l + o;
      sl = (l >= 8) ? l - 16 : l;
      so = (o >= 8) ? o - 16 : o;
      return mk_e(4'(s), s > 15, ((sl + so) > 7) || ((sl + so) < -8));
   endfunction

   task automatic send(input logic [1:0] m, input logic [3:0] aa, input logic [3:0] c0,
                       input logic [3:0] c1, input logic s, input exp_t e);
      int n;
      @(negedge clk);
      mode = m; a = aa; ops = {c1, c0}; sel = s; in_valid = 1'b1;
      if (rand_bp) out_ready = 1'($urandom_range(0, 1));
      #1;
      n = 0;
      while (!in_ready && n < 20) begin
         @(negedge clk);
         if (rand_bp) out_ready = (n >= 3) ? 1'b1 : 1'($urandom_range(0, 1));
         #1;
         n++;
      end
      if (!in_ready) begin
         checks++;
         errors++;
         $display("FAIL send_timeout: in_ready got 0, expected 1");
      end else begin
         q.push_back(e);
      end
   endtask

   task automatic idle();
      @(negedge clk);
      in_valid = 1'b0;
   endtask

   // Scoreboard drain: a result leaves whenever out_valid && out_ready at the next edge.
   always @(negedge clk) begin
      #2;
      if (!rst && out_valid && out_ready) begin
         if (q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_result: got res %0h, expected no result", res);
         end else begin
            mon_e = q.pop_front();
            chk("sb_res", res, mon_e.res);
            chk("sb_carry", carry, mon_e.carry);
            chk("sb_ovf", ovf, mon_e.ovf);
            chk("sb_sel_err", sel_err, mon_e.serr);
         end
      end
   end

   logic [3:0] r_a, r_c0, r_c1;
   logic       r_s;
   logic [1:0] s3_sel [4];
   logic [1:0] s3_mode[4];
   logic [3:0] s3_res [4];
   logic       s3_err [4];

   initial begin
      rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
      a = '0; ops = '0; sel = '0; mode = '0;
      in_valid3 = 1'b0; out_ready3 = 1'b1; a3 = '0; ops3 = '0; sel3 = '0; mode3 = '0;

      repeat (2) @(negedge clk);
      rst = 1'b0;
      #1;
      chk("rst_res", res, 0);
      chk("rst_carry", carry, 0);
      chk("rst_ovf", ovf, 0);
      chk("rst_sel_err", sel_err, 0);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_in_ready", in_ready, 1);
      chk("rst_out_valid3", out_valid3, 0);

      // NCH=3 instance: out-of-range select reads zero and flags sel_err.
      ops3 = {4'h2, 4'h5, 4'h3};
      a3   = 4'h6;
      s3_sel  = '{2'd3, 2'd2, 2'd3, 2'd1};
      s3_mode = '{MODE_ADD, MODE_ADD, MODE_ACC, MODE_ACC};
      s3_res  = '{4'h6, 4'h8, 4'h0, 4'h5};
      s3_err  = '{1'b1, 1'b0, 1'b1, 1'b0};
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         if (i > 0) begin
            #1;
            chk("nch3_res", res3, s3_res[i-1]);
            chk("nch3_sel_err", sel_err3, s3_err[i-1]);
            chk("nch3_out_valid", out_valid3, 1);
         end
         in_valid3 = 1'b1; sel3 = s3_sel[i]; mode3 = s3_mode[i];
      end
      @(negedge clk);
      in_valid3 = 1'b0;
      #1;
      chk("nch3_res", res3, s3_res[3]);
      chk("nch3_sel_err", sel_err3, s3_err[3]);

      // Vector table: {mode, a, ch0, ch1, sel, res, carry, ovf}.
      tbl.push_back(mk(MODE_ADD, 4'h3, 4'h5, 4'h9, 1'b1, 4'hC, 1'b0, 1'b0));
      tbl.push_back(mk(MODE_ADD, 4'h3, 4'h4, 4'hA, 1'b0, 4'h7, 1'b0, 1'b0));
      tbl.push_back(mk(MODE_ADD, 4'hF, 4'h1, 4'h6, 1'b0, 4'h0, 1'b1, 1'b0));
      tbl.push_back(mk(MODE_CLR, 4'h9, 4'h3, 4'h7, 1'b0, 4'h0, 1'b0, 1'b0));
      tbl.push_back(mk(MODE_ACC, 4'h0, 4'h5, 4'hB, 1'b0, 4'h5, 1'b0, 1'b0));
      tbl.push_back(mk(MODE_ACC, 4'h0, 4'h5, 4'hB, 1'b0, 4'hA, 1'b0, 1'b1));
      tbl.push_back(mk(MODE_SUB, 4'h0, 4'h5, 4'hB, 1'b1, 4'hF, 1'b1, 1'b0));
      tbl.push_back(mk(MODE_ADD, 4'h7, 4'h1, 4'h3, 1'b0, 4'h8, 1'b0, 1'b1));
      tbl.push_back(mk(MODE_ACC, 4'h2, 4'h1, 4'h3, 1'b0, 4'h0, 1'b1, 1'b0));
      tbl.push_back(mk(MODE_SUB, 4'h2, 4'h1, 4'h3, 1'b0, 4'hF, 1'b1, 1'b0));
      tbl.push_back(mk(MODE_SUB, 4'h2, 4'h1, 4'h7, 1'b1, 4'h8, 1'b0, 1'b0));
      tbl.push_back(mk(MODE_SUB, 4'h2, 4'h1, 4'h7, 1'b0, 4'h7, 1'b0, 1'b1));
      tbl.push_back(mk(MODE_CLR, 4'h2, 4'hE, 4'h7, 1'b1, 4'h0, 1'b0, 1'b0));
      foreach (tbl[i]) send(tbl[i].mode, tbl[i].a, tbl[i].ch0, tbl[i].ch1, tbl[i].s, tbl[i].e);
      idle();

      // Random ADD beats under random backpressure; acc stays 0.
      rand_bp = 1'b1;
      for (int i = 0; i < 12; i++) begin
         r_a  = 4'($urandom_range(0, 15));
         r_c0 = 4'($urandom_range(0, 15));
         r_c1 = 4'($urandom_range(0, 15));
         r_s  = 1'($urandom_range(0, 1));
         send(MODE_ADD, r_a, r_c0, r_c1, r_s, ref_add(int'(r_a), int'(r_s ? r_c1 : r_c0)));
      end
      rand_bp = 1'b0;
      idle();
      out_ready = 1'b1;
      repeat (3) @(negedge clk);

      // Backpressure: held result and stalled input, then accept on release.
      @(negedge clk);
      mode = MODE_ACC; a = 4'h0; ops = {4'h6, 4'h1}; sel = 1'b0; in_valid = 1'b1;
      #1;
      chk("bp_first_ready", in_ready, 1);
      q.push_back(mk_e(4'h1, 1'b0, 1'b0));
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         out_ready = 1'b0;
         #1;
         chk("bp_in_ready", in_ready, 0);
         chk("bp_res_hold", res, 1);
         chk("bp_out_valid", out_valid, 1);
      end
      @(negedge clk);
      out_ready = 1'b1;
      #1;
      chk("bp_release_ready", in_ready, 1);
      q.push_back(mk_e(4'h2, 1'b0, 1'b0));
      @(negedge clk);
      in_valid = 1'b0;
      #1;
      chk("bp_next_res", res, 2);
      chk("bp_next_valid", out_valid, 1);
      @(negedge clk);

      // Reset while a result is pending.
      send(MODE_CLR, 4'h0, 4'h0, 4'h0, 1'b0, mk_e(4'h0, 1'b0, 1'b0));
      send(MODE_ACC, 4'h0, 4'h7, 4'h0, 1'b0, mk_e(4'h7, 1'b0, 1'b0));
      @(negedge clk);
      in_valid = 1'b0; out_ready = 1'b0;
      #1;
      chk("mid_pending_res", res, 7);
      @(negedge clk);
      rst = 1'b1; in_valid = 1'b1; mode = MODE_ACC; ops = 8'hFF;
      q.delete();
      @(negedge clk);
      rst = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
      #1;
      chk("mid_rst_out_valid", out_valid, 0);
      chk("mid_rst_res", res, 0);
      chk("mid_rst_in_ready", in_ready, 1);
      send(MODE_ACC, 4'h0, 4'h1, 4'h0, 1'b0, mk_e(4'h1, 1'b0, 1'b0));
      idle();
      #1;
      chk("mid_after_res", res, 1);
      repeat (3) @(negedge clk);
      chk("queue_empty", q.size(), 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
